// File: rtl/gadget.sv
// Power-up manager for the 16x16 arena: hidden gadgets, reveal by blast,
// pickup by players, and per-player bomb capacity / blast length counters.
module gadget #(
  parameter int CAP_INIT = 1,
  parameter int CAP_MAX  = 5,
  parameter int LEN_INIT = 1,
  parameter int LEN_MAX  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   p1_cor,
  input  logic [7:0]   p2_cor,
  input  logic [255:0] i_explode,
  output logic [2:0]   o_p1_cap,
  output logic [2:0]   o_p2_cap,
  output logic [1:0]   o_p1_len,
  output logic [1:0]   o_p2_len,
  output logic [2:0]   o_gadget_state_grid [0:255],
  output logic         p2_able_to_add_bomb
);

  localparam logic [2:0] CAP_INIT_V = 3'(CAP_INIT);
  localparam logic [2:0] CAP_MAX_V  = 3'(CAP_MAX);
  localparam logic [1:0] LEN_INIT_V = 2'(LEN_INIT);
  localparam logic [1:0] LEN_MAX_V  = 2'(LEN_MAX);

  localparam logic [2:0] ST_NONE   = 3'd0;
  localparam logic [2:0] ST_HID_B  = 3'd1;
  localparam logic [2:0] ST_HID_R  = 3'd2;
  localparam logic [2:0] ST_REV_B  = 3'd3;
  localparam logic [2:0] ST_REV_R  = 3'd4;

  logic [2:0] grid [0:255];
  logic [2:0] p1_tile, p2_tile;
  logic       p1_take, p2_take;

  function automatic logic [2:0] init_tile(input logic [7:0] idx);
    if (idx[1:0] == 2'd1 && idx[5:4] == 2'd3)
      return ST_HID_B;
    else if (idx[1:0] == 2'd3 && idx[5:4] == 2'd1)
      return ST_HID_R;
    else
      return ST_NONE;
  endfunction

  assign p1_tile = grid[p1_cor];
  assign p2_tile = grid[p2_cor];
  assign p1_take = (p1_tile == ST_REV_B) || (p1_tile == ST_REV_R);
  // Shared tile goes to player 1 only.
  assign p2_take = ((p2_tile == ST_REV_B) || (p2_tile == ST_REV_R)) && (p2_cor != p1_cor);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        grid[i] <= init_tile(8'(i));
      o_p1_cap <= CAP_INIT_V;
      o_p2_cap <= CAP_INIT_V;
      o_p1_len <= LEN_INIT_V;
      o_p2_len <= LEN_INIT_V;
    end else begin
      // Only hidden tiles react to a blast; revealed/empty tiles ignore it.
      for (int i = 0; i < 256; i++) begin
        if (i_explode[i] && (grid[i] == ST_HID_B || grid[i] == ST_HID_R))
          grid[i] <= grid[i] + 3'd2;
      end
      if (p1_take) begin
        grid[p1_cor] <= ST_NONE;
        if (p1_tile == ST_REV_B && o_p1_cap < CAP_MAX_V)
          o_p1_cap <= o_p1_cap + 3'd1;
        if (p1_tile == ST_REV_R && o_p1_len < LEN_MAX_V)
          o_p1_len <= o_p1_len + 2'd1;
      end
      if (p2_take) begin
        grid[p2_cor] <= ST_NONE;
        if (p2_tile == ST_REV_B && o_p2_cap < CAP_MAX_V)
          o_p2_cap <= o_p2_cap + 3'd1;
        if (p2_tile == ST_REV_R && o_p2_len < LEN_MAX_V)
          o_p2_len <= o_p2_len + 2'd1;
      end
    end
  end

  assign o_gadget_state_grid = grid;
  assign p2_able_to_add_bomb = (o_p2_cap < CAP_MAX_V);

endmodule

// File: tb/tb_gadget.sv
// Bench for gadget: directed test-plan sequence followed by randomized play,
// all checked against a tile-level reference model.
module tb_gadget;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   p1_cor, p2_cor;
  logic [255:0] i_explode;
  logic [2:0]   o_p1_cap, o_p2_cap;
  logic [1:0]   o_p1_len, o_p2_len;
  logic [2:0]   grid_o [0:255];
  logic         p2_able;

  int total = 0;
  int bad   = 0;

  int m_grid [256];
  int m_cap1, m_cap2, m_len1, m_len2;

  gadget dut (
    .clk                 (clk),
    .rst                 (rst),
    .p1_cor              (p1_cor),
    .p2_cor              (p2_cor),
    .i_explode           (i_explode),
    .o_p1_cap            (o_p1_cap),
    .o_p2_cap            (o_p2_cap),
    .o_p1_len            (o_p1_len),
    .o_p2_len            (o_p2_len),
    .o_gadget_state_grid (grid_o),
    .p2_able_to_add_bomb (p2_able)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int layout(input int idx);
    int x, y;
    x = idx % 16;
    y = idx / 16;
    if (x % 4 == 1 && y % 4 == 3) return 1;
    if (x % 4 == 3 && y % 4 == 1) return 2;
    return 0;
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int nxt [256];
    int a, b;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_grid[i] = layout(i);
      m_cap1 = 1; m_cap2 = 1; m_len1 = 1; m_len2 = 1;
      return;
    end
    nxt = m_grid;
    for (int i = 0; i < 256; i++)
      if (i_explode[i] && (m_grid[i] == 1 || m_grid[i] == 2))
        nxt[i] = m_grid[i] + 2;
    a = int'(p1_cor);
    b = int'(p2_cor);
    if (m_grid[a] == 3 || m_grid[a] == 4) begin
      if (m_grid[a] == 3) m_cap1 = sat_inc(m_cap1, 5);
      else                m_len1 = sat_inc(m_len1, 3);
      nxt[a] = 0;
    end
    if (b != a && (m_grid[b] == 3 || m_grid[b] == 4)) begin
      if (m_grid[b] == 3) m_cap2 = sat_inc(m_cap2, 5);
      else                m_len2 = sat_inc(m_len2, 3);
      nxt[b] = 0;
    end
    m_grid = nxt;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int d;
    d = 0;
    for (int i = 0; i < 256; i++)
      if (int'(grid_o[i]) != m_grid[i]) d++;
    chk({tag, "_grid_diff"}, d, 0);
    chk({tag, "_p1_cap"}, int'(o_p1_cap), m_cap1);
    chk({tag, "_p2_cap"}, int'(o_p2_cap), m_cap2);
    chk({tag, "_p1_len"}, int'(o_p1_len), m_len1);
    chk({tag, "_p2_len"}, int'(o_p2_len), m_len2);
    chk({tag, "_p2_able"}, int'(p2_able), (m_cap2 < 5) ? 1 : 0);
  endtask

  function automatic logic [7:0] pick_tile();
    int gx, gy;
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 255));
    gx = $urandom_range(0, 3) * 4;
    gy = $urandom_range(0, 3) * 4;
    if ($urandom_range(0, 1) == 0) return 8'((gy + 3) * 16 + gx + 1);
    return 8'((gy + 1) * 16 + gx + 3);
  endfunction

  logic [7:0] bomb_list [5];

  initial begin
    bomb_list[0] = 8'h31; bomb_list[1] = 8'h35; bomb_list[2] = 8'h39;
    bomb_list[3] = 8'h3D; bomb_list[4] = 8'h71;
    for (int i = 0; i < 256; i++) m_grid[i] = 0;
    m_cap1 = 0; m_cap2 = 0; m_len1 = 0; m_len2 = 0;
    rst = 1'b1; p1_cor = 8'h00; p2_cor = 8'hFF; i_explode = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("rst_g31", int'(grid_o[8'h31]), 1);
    chk("rst_g13", int'(grid_o[8'h13]), 2);
    chk("rst_g00", int'(grid_o[8'h00]), 0);
    chk("rst_cap1", int'(o_p1_cap), 1);
    chk("rst_cap2", int'(o_p2_cap), 1);
    chk("rst_len1", int'(o_p1_len), 1);
    chk("rst_len2", int'(o_p2_len), 1);
    chk("rst_able", int'(p2_able), 1);
    check_all("rst");

    // Reveal 0x31 and keep the blast up; tile must stay revealed.
    i_explode[8'h31] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("reveal_g31", int'(grid_o[8'h31]), 3);
    end
    i_explode = '0;

    p1_cor = 8'h31;
    step();
    chk("p1pick_g31", int'(grid_o[8'h31]), 0);
    chk("p1pick_cap1", int'(o_p1_cap), 2);
    chk("p1pick_cap2", int'(o_p2_cap), 1);
    p1_cor = 8'h00;

    i_explode[8'h13] = 1'b1;
    step();
    chk("reveal_g13", int'(grid_o[8'h13]), 4);
    i_explode = '0;
    p1_cor = 8'h13; p2_cor = 8'h13;
    step();
    chk("share_len1", int'(o_p1_len), 2);
    chk("share_len2", int'(o_p2_len), 1);
    chk("share_g13", int'(grid_o[8'h13]), 0);
    p1_cor = 8'h00; p2_cor = 8'hFF;
    check_all("share");

    // Fresh layout, then player 2 walks over five revealed bomb-ups.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) i_explode[bomb_list[k]] = 1'b1;
    step();
    i_explode = '0;
    for (int k = 0; k < 5; k++) begin
      p2_cor = bomb_list[k];
      step();
      chk("p2run_cap2", int'(o_p2_cap), (k + 2 > 5) ? 5 : k + 2);
      chk("p2run_able", int'(p2_able), (k >= 3) ? 0 : 1);
    end
    for (int k = 0; k < 5; k++) chk("p2run_tile", int'(grid_o[bomb_list[k]]), 0);
    p2_cor = 8'hFF;
    check_all("p2run");

    // Same-cycle reveal and pickup, then collect, then mid-game reset.
    i_explode[8'h75] = 1'b1;
    p1_cor = 8'h75;
    step();
    chk("same_g75", int'(grid_o[8'h75]), 3);
    chk("same_cap1", int'(o_p1_cap), 1);
    i_explode = '0;
    step();
    chk("late_g75", int'(grid_o[8'h75]), 0);
    chk("late_cap1", int'(o_p1_cap), 2);
    i_explode = '1;
    p1_cor = 8'h17;
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_explode = '0;
    chk("mrst_g75", int'(grid_o[8'h75]), 1);
    chk("mrst_g17", int'(grid_o[8'h17]), 2);
    chk("mrst_cap1", int'(o_p1_cap), 1);
    chk("mrst_cap2", int'(o_p2_cap), 1);
    chk("mrst_able", int'(p2_able), 1);
    check_all("mrst");

    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      i_explode = '0;
      for (int k = $urandom_range(0, 4); k > 0; k--) i_explode[pick_tile()] = 1'b1;
      p1_cor = pick_tile();
      p2_cor = ($urandom_range(0, 7) == 0) ? p1_cor : pick_tile();
      step();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
